// File: rtl/mem_bridge.sv
// T8086 byte bus to 512Kx16 asynchronous SRAM bridge with programmable wait states.
// Optional single-entry read cache: define MEM_BRIDGE_RCACHE_EN.
module mem_bridge #(
   parameter int unsigned WAIT = 1
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [19:0] a,
   input  logic [7:0]  o,
   input  logic        w,
   output logic [7:0]  i,
   output logic        ce,
   output logic [18:0] sram_a,
   output logic [15:0] sram_d,
   input  logic [15:0] sram_q,
   output logic        sram_doe,
   output logic        sram_we_n,
   output logic        sram_oe_n,
   output logic        sram_lb_n,
   output logic        sram_ub_n
);

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ACCESS = 2'd1, ST_DONE = 2'd2} state_t;

   localparam logic [3:0] WAIT_C = 4'(WAIT);

   function automatic logic [7:0] byte_sel(input logic [15:0] word, input logic hi);
      return hi ? word[15:8] : word[7:0];
   endfunction

   state_t      state_q;
   logic [3:0]  cnt_q;
   logic [19:0] a_q;
   logic [7:0]  o_q;
   logic        w_q;
   logic [7:0]  i_q;
   logic        ce_q;
   logic        doe_q;
   logic        we_n_q;
   logic        oe_n_q;
   logic        lb_n_q;
   logic        ub_n_q;

   logic        hit_d;
   logic [7:0]  hit_byte_d;

`ifdef MEM_BRIDGE_RCACHE_EN
   logic [15:0] cache_word_q;
   logic [18:0] cache_tag_q;
   logic        cache_vld_q;
   logic        wr_hit_d;
`endif

   // Cache lookup against the address the CPU presents during IDLE.
   always_comb begin
      hit_d      = 1'b0;
      hit_byte_d = 8'h00;
`ifdef MEM_BRIDGE_RCACHE_EN
      wr_hit_d   = 1'b0;
      if (cache_vld_q && (cache_tag_q == a[19:1])) begin
         hit_d    = ~w;
         wr_hit_d = w;
      end else begin
         hit_d    = 1'b0;
         wr_hit_d = 1'b0;
      end
      hit_byte_d = byte_sel(cache_word_q, a[0]);
`endif
   end

   // Access sequencer; every output is taken straight from a flop.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         a_q     <= 20'h00000;
         o_q     <= 8'h00;
         w_q     <= 1'b0;
         i_q     <= 8'h00;
         ce_q    <= 1'b0;
         doe_q   <= 1'b0;
         we_n_q  <= 1'b1;
         oe_n_q  <= 1'b1;
         lb_n_q  <= 1'b1;
         ub_n_q  <= 1'b1;
`ifdef MEM_BRIDGE_RCACHE_EN
         cache_word_q <= 16'h0000;
         cache_tag_q  <= 19'h00000;
         cache_vld_q  <= 1'b0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               a_q   <= a;
               o_q   <= o;
               w_q   <= w;
               cnt_q <= WAIT_C;
               ce_q  <= 1'b0;
               if (hit_d) begin
                  state_q <= ST_DONE;
                  ce_q    <= 1'b1;
                  i_q     <= hit_byte_d;
               end else if (w) begin
                  state_q <= ST_ACCESS;
                  we_n_q  <= 1'b0;
                  doe_q   <= 1'b1;
                  lb_n_q  <= a[0];
                  ub_n_q  <= ~a[0];
               end else begin
                  state_q <= ST_ACCESS;
                  oe_n_q  <= 1'b0;
                  lb_n_q  <= 1'b0;
                  ub_n_q  <= 1'b0;
               end
`ifdef MEM_BRIDGE_RCACHE_EN
               // Write-through: keep the cached copy coherent with the SRAM write.
               if (wr_hit_d) begin
                  if (a[0]) begin
                     cache_word_q[15:8] <= o;
                  end else begin
                     cache_word_q[7:0] <= o;
                  end
               end
`endif
            end
            ST_ACCESS: begin
               ce_q <= 1'b0;
               if (cnt_q == 4'd0) begin
                  state_q <= ST_DONE;
                  ce_q    <= 1'b1;
                  doe_q   <= 1'b0;
                  we_n_q  <= 1'b1;
                  oe_n_q  <= 1'b1;
                  lb_n_q  <= 1'b1;
                  ub_n_q  <= 1'b1;
                  if (!w_q) begin
                     i_q <= byte_sel(sram_q, a_q[0]);
`ifdef MEM_BRIDGE_RCACHE_EN
                     cache_word_q <= sram_q;
                     cache_tag_q  <= a_q[19:1];
                     cache_vld_q  <= 1'b1;
`endif
                  end
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
               ce_q    <= 1'b0;
            end
            default: begin
               state_q <= ST_IDLE;
               ce_q    <= 1'b0;
               doe_q   <= 1'b0;
               we_n_q  <= 1'b1;
               oe_n_q  <= 1'b1;
               lb_n_q  <= 1'b1;
               ub_n_q  <= 1'b1;
            end
         endcase
      end
   end

   // Address and data come from the latched request, so DONE gives write hold time.
   assign sram_a    = a_q[19:1];
   assign sram_d    = {o_q, o_q};
   assign i         = i_q;
   assign ce        = ce_q;
   assign sram_doe  = doe_q;
   assign sram_we_n = we_n_q;
   assign sram_oe_n = oe_n_q;
   assign sram_lb_n = lb_n_q;
   assign sram_ub_n = ub_n_q;

endmodule

// File: tb/tb_mem_bridge.sv
// Directed self-checking bench for mem_bridge (WAIT=1, plus WAIT=0/15 period instances).
module tb_mem_bridge;

   logic        clock = 1'b0;
   logic        reset_n;
   logic [19:0] a;
   logic [7:0]  o;
   logic        w;
   logic [7:0]  i;
   logic        ce;
   logic [18:0] sram_a;
   logic [15:0] sram_d;
   logic [15:0] sram_q;
   logic        sram_doe, sram_we_n, sram_oe_n, sram_lb_n, sram_ub_n;

   logic [7:0]  i0, i15;
   logic        ce0, ce15;
   logic [18:0] sa0, sa15;
   logic [15:0] sd0, sd15;
   logic        doe0, we0, oe0, lb0, ub0;
   logic        doe15, we15, oe15, lb15, ub15;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   mem_bridge #(.WAIT(1)) u_dut (
      .clock(clock), .reset_n(reset_n), .a(a), .o(o), .w(w), .i(i), .ce(ce),
      .sram_a(sram_a), .sram_d(sram_d), .sram_q(sram_q), .sram_doe(sram_doe),
      .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n), .sram_lb_n(sram_lb_n), .sram_ub_n(sram_ub_n)
   );

   mem_bridge #(.WAIT(0)) u_w0 (
      .clock(clock), .reset_n(reset_n), .a(20'h00000), .o(8'h00), .w(1'b0), .i(i0), .ce(ce0),
      .sram_a(sa0), .sram_d(sd0), .sram_q(16'h0000), .sram_doe(doe0),
      .sram_we_n(we0), .sram_oe_n(oe0), .sram_lb_n(lb0), .sram_ub_n(ub0)
   );

   mem_bridge #(.WAIT(15)) u_w15 (
      .clock(clock), .reset_n(reset_n), .a(20'h00000), .o(8'h00), .w(1'b0), .i(i15), .ce(ce15),
      .sram_a(sa15), .sram_d(sd15), .sram_q(16'h0000), .sram_doe(doe15),
      .sram_we_n(we15), .sram_oe_n(oe15), .sram_lb_n(lb15), .sram_ub_n(ub15)
   );

   // Small SRAM model: 1K words are enough for the addresses used here.
   logic [15:0] mem [0:1023];
   logic        pre_we;
   logic [9:0]  pre_a;
   logic [15:0] pre_d;

   always @(posedge clock) begin
      if (pre_we) begin
         mem[pre_a] <= pre_d;
      end else if (!sram_we_n) begin
         if (!sram_lb_n) mem[sram_a[9:0]][7:0]  <= sram_d[7:0];
         if (!sram_ub_n) mem[sram_a[9:0]][15:8] <= sram_d[15:8];
      end
   end

   assign sram_q = mem[sram_a[9:0]];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   int          lat, n_oe, n_we, n_lb, n_ub, n_doe;
   logic [18:0] acc_a, done_a;
   logic [15:0] acc_d, done_d;
   logic [4:0]  done_str;

   // Called at the falling edge of an IDLE cycle; returns at the falling edge of the next IDLE.
   task automatic run_op(input string tag, input logic [19:0] addr, input logic [7:0] data, input logic wr);
      bit seen;
      seen = 1'b0;
      a = addr; o = data; w = wr;
      lat = 1; n_oe = 0; n_we = 0; n_lb = 0; n_ub = 0; n_doe = 0;
      acc_a = 19'h7FFFF; acc_d = 16'hFFFF;
      for (int k = 0; k < 40; k++) begin
         @(negedge clock);
         lat++;
         if (ce) begin
            seen = 1'b1;
            break;
         end
         if (!sram_oe_n) n_oe++;
         if (!sram_we_n) n_we++;
         if (!sram_lb_n) n_lb++;
         if (!sram_ub_n) n_ub++;
         if (sram_doe)   n_doe++;
         acc_a = sram_a;
         acc_d = sram_d;
      end
      check_eq({tag, "_ce_seen"}, 32'(seen), 32'd1);
      done_str = {sram_we_n, sram_oe_n, sram_lb_n, sram_ub_n, sram_doe};
      done_a   = sram_a;
      done_d   = sram_d;
      check_eq({tag, "_done_strobes"}, 32'(done_str), 32'h1E);
      @(negedge clock);
      check_eq({tag, "_ce_single"}, 32'(ce), 32'd0);
   endtask

   task automatic measure(input bit slow, output int per);
      bit seen;
      seen = 1'b0;
      per  = 0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clock);
         if (slow ? ce15 : ce0) begin
            seen = 1'b1;
            break;
         end
      end
      if (seen) begin
         for (int k = 0; k < 60; k++) begin
            @(negedge clock);
            per++;
            if (slow ? ce15 : ce0) break;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int  per;
      bit  found;
      reset_n = 1'b0;
      a = 20'h00021; o = 8'h00; w = 1'b0;
      pre_we = 1'b0; pre_a = 10'h000; pre_d = 16'h0000;

      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         check_eq("rst_ce", 32'(ce), 32'd0);
      end
      pre_we = 1'b1; pre_a = 10'h010; pre_d = 16'hBEEF;
      @(negedge clock);
      pre_a = 10'h011; pre_d = 16'h1234;
      @(negedge clock);
      pre_we = 1'b0;
      check_eq("rst_i",    32'(i),         32'h00);
      check_eq("rst_ce2",  32'(ce),        32'd0);
      check_eq("rst_we",   32'(sram_we_n), 32'd1);
      check_eq("rst_oe",   32'(sram_oe_n), 32'd1);
      check_eq("rst_lb",   32'(sram_lb_n), 32'd1);
      check_eq("rst_ub",   32'(sram_ub_n), 32'd1);
      check_eq("rst_doe",  32'(sram_doe),  32'd0);
      check_eq("rst_addr", 32'(sram_a),    32'h0);
      check_eq("rst_data", 32'(sram_d),    32'h0);
      reset_n = 1'b1;

      run_op("rd21", 20'h00021, 8'h00, 1'b0);
      check_eq("rd21_lat",  32'(lat),   32'd4);
      check_eq("rd21_oe",   32'(n_oe),  32'd2);
      check_eq("rd21_we",   32'(n_we),  32'd0);
      check_eq("rd21_addr", 32'(acc_a), 32'h10);
      check_eq("rd21_i",    32'(i),     32'hBE);

      run_op("wr20", 20'h00020, 8'h5A, 1'b1);
      check_eq("wr20_lat",   32'(lat),    32'd4);
      check_eq("wr20_we",    32'(n_we),   32'd2);
      check_eq("wr20_lb",    32'(n_lb),   32'd2);
      check_eq("wr20_ub",    32'(n_ub),   32'd0);
      check_eq("wr20_oe",    32'(n_oe),   32'd0);
      check_eq("wr20_doe",   32'(n_doe),  32'd2);
      check_eq("wr20_d",     32'(acc_d),  32'h5A5A);
      check_eq("wr20_hold_a", 32'(done_a), 32'h10);
      check_eq("wr20_hold_d", 32'(done_d), 32'h5A5A);
      check_eq("wr20_mem",   32'(mem[10'h010]), 32'hBE5A);

      run_op("rd23", 20'h00023, 8'h00, 1'b0);
      check_eq("rd23_lat", 32'(lat), 32'd4);
      check_eq("rd23_i",   32'(i),   32'h12);

      run_op("wr23", 20'h00023, 8'hC3, 1'b1);
      check_eq("wr23_ub",  32'(n_ub), 32'd2);
      check_eq("wr23_lb",  32'(n_lb), 32'd0);
      check_eq("wr23_mem", 32'(mem[10'h011]), 32'hC334);

      run_op("rd20", 20'h00020, 8'h00, 1'b0);
      check_eq("rd20_lat", 32'(lat),  32'd4);
      check_eq("rd20_oe",  32'(n_oe), 32'd2);
      check_eq("rd20_i",   32'(i),    32'h5A);

      measure(1'b0, per);
      check_eq("period_w0", 32'(per), 32'd3);
      measure(1'b1, per);
      check_eq("period_w15", 32'(per), 32'd18);

      // Realign with the main bridge, which kept repeating its last read.
      found = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clock);
         if (ce) begin
            found = 1'b1;
            break;
         end
      end
      check_eq("resync", 32'(found), 32'd1);
      @(negedge clock);

      a = 20'h00061; o = 8'h77; w = 1'b1;
      @(negedge clock);
      @(negedge clock);
      check_eq("rmid_we_pre", 32'(sram_we_n), 32'd0);
      reset_n = 1'b0;
      @(negedge clock);
      check_eq("rmid_we",  32'(sram_we_n), 32'd1);
      check_eq("rmid_doe", 32'(sram_doe),  32'd0);
      check_eq("rmid_ub",  32'(sram_ub_n), 32'd1);
      check_eq("rmid_ce",  32'(ce),        32'd0);
      reset_n = 1'b1;

      run_op("rd22", 20'h00022, 8'h00, 1'b0);
      check_eq("rd22_lat", 32'(lat), 32'd4);
      check_eq("rd22_i",   32'(i),   32'h34);

`ifdef MEM_BRIDGE_RCACHE_EN
      run_op("c_rd20", 20'h00020, 8'h00, 1'b0);
      check_eq("c_rd20_lat", 32'(lat), 32'd4);
      check_eq("c_rd20_i",   32'(i),   32'h5A);
      run_op("c_rd21", 20'h00021, 8'h00, 1'b0);
      check_eq("c_rd21_lat", 32'(lat),  32'd2);
      check_eq("c_rd21_oe",  32'(n_oe), 32'd0);
      check_eq("c_rd21_i",   32'(i),    32'hBE);
      run_op("c_wr21", 20'h00021, 8'h11, 1'b1);
      check_eq("c_wr21_lat", 32'(lat),  32'd4);
      check_eq("c_wr21_we",  32'(n_we), 32'd2);
      check_eq("c_wr21_mem", 32'(mem[10'h010]), 32'h115A);
      run_op("c_rd21b", 20'h00021, 8'h00, 1'b0);
      check_eq("c_rd21b_lat", 32'(lat),  32'd2);
      check_eq("c_rd21b_oe",  32'(n_oe), 32'd0);
      check_eq("c_rd21b_i",   32'(i),    32'h11);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
